// File: rtl/scroll_engine.sv
// Vertical scroll / score / difficulty engine for the crossy-road playfield.
// Optional build macro SCROLL_BCD_EN adds a packed two-digit BCD copy of the score.
module scroll_engine #(
    parameter int Y_W           = 10,
    parameter int SCREEN_HEIGHT = 480,
    parameter int TICK_CYCLES   = 100000,
    parameter int STEP          = 2,
    parameter int SCORE_TICKS   = 10,
    parameter int SCORE_W       = 7,
    parameter int SCORE_MAX     = 99,
    parameter int LEVEL_SCORE   = 10,
    parameter int NUM_LEVELS    = 4,
    localparam int LVL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               move_btn,
    input  logic               restart,
    output logic [Y_W-1:0]     y_pos,
    output logic [SCORE_W-1:0] score,
    output logic [LVL_W-1:0]   level,
    output logic               move_followers,
    output logic               wrap,
`ifdef SCROLL_BCD_EN
    output logic [7:0]         score_bcd,
`endif
    output logic               done
);

    localparam int TC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int ST_W = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
    localparam int LS_W = (LEVEL_SCORE > 1) ? $clog2(LEVEL_SCORE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [TC_W-1:0]    tick_cnt_r;
    logic [ST_W-1:0]    score_tick_r;
    logic [LS_W-1:0]    lvl_cnt_r;
    logic [Y_W-1:0]     y_r;
    logic [SCORE_W-1:0] score_r;
    logic [LVL_W-1:0]   level_r;
    logic               mf_r;
    logic               wrap_r;
    logic               done_r;
`ifdef SCROLL_BCD_EN
    logic [7:0]         bcd_r;
`endif

    logic               freeze_s;
    logic               count_s;
    logic               tick_s;
    logic [Y_W:0]       step_s;
    logic [Y_W:0]       sum_s;
    logic               wrap_s;
    logic [Y_W:0]       y_next_s;
    logic               inc_score_s;
    logic               level_up_s;

    // Tick detection, next scroll offset (one extra bit so SCREEN_HEIGHT = 2^Y_W cannot overflow) and score/level events.
    always_comb begin
        freeze_s    = 1'b0;
        count_s     = 1'b0;
        tick_s      = 1'b0;
        step_s      = {(Y_W+1){1'b0}};
        sum_s       = {(Y_W+1){1'b0}};
        wrap_s      = 1'b0;
        y_next_s    = {(Y_W+1){1'b0}};
        inc_score_s = 1'b0;
        level_up_s  = 1'b0;

        // Saturated score freezes everything one cycle before DONE is visible.
        freeze_s = (state_r == ST_DONE) || (score_r == SCORE_W'(SCORE_MAX));
        count_s  = move_btn && !freeze_s;
        tick_s   = count_s && (tick_cnt_r == TC_W'(TICK_CYCLES - 1));
        step_s   = (Y_W+1)'(STEP) + (Y_W+1)'(level_r);
        sum_s    = {1'b0, y_r} + step_s;
        wrap_s   = (sum_s >= (Y_W+1)'(SCREEN_HEIGHT));
        if (wrap_s) begin
            y_next_s = sum_s - (Y_W+1)'(SCREEN_HEIGHT);
        end else begin
            y_next_s = sum_s;
        end
        inc_score_s = tick_s && (score_tick_r == ST_W'(SCORE_TICKS - 1))
                      && (score_r < SCORE_W'(SCORE_MAX));
        level_up_s  = inc_score_s && (lvl_cnt_r == LS_W'(LEVEL_SCORE - 1));
    end

    // Run-state FSM plus all counters and registered outputs; restart clears exactly like reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            tick_cnt_r   <= {TC_W{1'b0}};
            score_tick_r <= {ST_W{1'b0}};
            lvl_cnt_r    <= {LS_W{1'b0}};
            y_r          <= {Y_W{1'b0}};
            score_r      <= {SCORE_W{1'b0}};
            level_r      <= {LVL_W{1'b0}};
            mf_r         <= 1'b0;
            wrap_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef SCROLL_BCD_EN
            bcd_r        <= 8'h00;
`endif
        end else if (restart) begin
            state_r      <= ST_IDLE;
            tick_cnt_r   <= {TC_W{1'b0}};
            score_tick_r <= {ST_W{1'b0}};
            lvl_cnt_r    <= {LS_W{1'b0}};
            y_r          <= {Y_W{1'b0}};
            score_r      <= {SCORE_W{1'b0}};
            level_r      <= {LVL_W{1'b0}};
            mf_r         <= 1'b0;
            wrap_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef SCROLL_BCD_EN
            bcd_r        <= 8'h00;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_RUN: begin
                    if (freeze_s) begin
                        state_r <= ST_DONE;
                    end else if (move_btn) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DONE: state_r <= ST_DONE;
                default: state_r <= ST_IDLE;
            endcase

            done_r <= freeze_s;
            mf_r   <= tick_s;
            wrap_r <= tick_s && wrap_s;

            if (tick_s) begin
                tick_cnt_r <= {TC_W{1'b0}};
            end else if (count_s) begin
                tick_cnt_r <= tick_cnt_r + TC_W'(1);
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end

            if (tick_s) begin
                y_r <= y_next_s[Y_W-1:0];
                if (score_tick_r == ST_W'(SCORE_TICKS - 1)) begin
                    score_tick_r <= {ST_W{1'b0}};
                end else begin
                    score_tick_r <= score_tick_r + ST_W'(1);
                end
            end else begin
                y_r          <= y_r;
                score_tick_r <= score_tick_r;
            end

            if (inc_score_s) begin
                score_r <= score_r + SCORE_W'(1);
                if (level_up_s) begin
                    lvl_cnt_r <= {LS_W{1'b0}};
                end else begin
                    lvl_cnt_r <= lvl_cnt_r + LS_W'(1);
                end
`ifdef SCROLL_BCD_EN
                if (bcd_r[3:0] == 4'd9) begin
                    bcd_r <= {bcd_r[7:4] + 4'd1, 4'd0};
                end else begin
                    bcd_r <= {bcd_r[7:4], bcd_r[3:0] + 4'd1};
                end
`endif
            end else begin
                score_r   <= score_r;
                lvl_cnt_r <= lvl_cnt_r;
            end

            if (level_up_s && (level_r != LVL_W'(NUM_LEVELS - 1))) begin
                level_r <= level_r + LVL_W'(1);
            end else begin
                level_r <= level_r;
            end
        end
    end

    assign y_pos          = y_r;
    assign score          = score_r;
    assign level          = level_r;
    assign move_followers = mf_r;
    assign wrap           = wrap_r;
    assign done           = done_r;
`ifdef SCROLL_BCD_EN
    assign score_bcd      = bcd_r;
`endif

endmodule

// File: doc/scroll_engine.md
Name: scroll_engine

Overview:
Parametrised vertical scroll and score engine for the crossy-road playfield. It advances a wrapping y offset while the player holds the move button and emits a one-cycle follower-move strobe on every scroll tick. It accumulates a saturating score and raises a difficulty level that enlarges the scroll step. It sits between the input debouncer and the obstacle/follower generators and the score renderer.

Parameters:
Y_W, 10, width of y_pos
SCREEN_HEIGHT, 480, wrap modulus for y_pos (must be <= 2^Y_W)
TICK_CYCLES, 100000, clk cycles of held move_btn per scroll tick
STEP, 2, base scroll step in lines per tick
SCORE_TICKS, 10, scroll ticks per score point
SCORE_W, 7, width of score
SCORE_MAX, 99, saturating score value; reaching it ends the run
LEVEL_SCORE, 10, score points per level increase
NUM_LEVELS, 4, number of levels (0..NUM_LEVELS-1); requires STEP+NUM_LEVELS-1 < SCREEN_HEIGHT

Ports:
clk  input  1  system clock (25 MHz pixel clock)
reset_n  input  1  asynchronous active-low reset
move_btn  input  1  level, already synchronised; high = scroll
restart  input  1  synchronous clear of the run state, any state
y_pos  output  Y_W  current scroll offset, 0..SCREEN_HEIGHT-1
score  output  SCORE_W  current score, 0..SCORE_MAX
level  output  $clog2(NUM_LEVELS)  current difficulty level
move_followers  output  1  one-cycle strobe per scroll tick
wrap  output  1  one-cycle strobe when y_pos wraps past SCREEN_HEIGHT
done  output  1  high while in DONE state

Behaviour:
- Single clock domain, clk. reset_n is asynchronous and active-low and clears all state. Reset values: y_pos=0, score=0, level=0, move_followers=0, wrap=0, done=0, internal counters=0, FSM=IDLE. All outputs are registered.
- FSM states:
  - IDLE: move_btn=0. Tick counter holds its value. Goes to RUN when move_btn=1.
  - RUN: move_btn=1. Tick counter increments each cycle. Goes back to IDLE when move_btn=0, and the counter keeps its value, as in IDLE.
  - DONE: entered on the cycle after score becomes SCORE_MAX. Scrolling, counting and strobes are frozen and done=1. Only reset_n or restart leave DONE.
- Tick: occurs in the cycle where the counter equals TICK_CYCLES-1 and move_btn=1. The counter then returns to 0. On the next edge:
  - move_followers=1 for exactly one cycle.
  - y_pos advances by step = STEP + level.
- Wrap: if y_pos + step >= SCREEN_HEIGHT, y_pos <= y_pos + step - SCREEN_HEIGHT (modular, not clamped to 0), and wrap=1 for one cycle, coincident with move_followers.
- Score: the tick-per-point counter increments on each tick. At a tick where it equals SCORE_TICKS-1, it returns to 0 and score increments. score saturates at SCORE_MAX and never exceeds it.
- Level: the level counter counts score increments. When it reaches LEVEL_SCORE, it clears and level increments, saturating at NUM_LEVELS-1.
  - The new step applies from the tick after the level change.
- Sum width: intermediate sums use Y_W+1 bits, so no overflow when SCREEN_HEIGHT = 2^Y_W.
- restart=1, sampled synchronously: all registers return to reset values on the next edge, from any state. restart has priority over a coincident tick.
- reset_n asserted mid-tick or mid-DONE: immediate clear. No strobe is emitted on reset release.
- Strobes are not emitted in IDLE or DONE.
- A tick coinciding with score reaching SCORE_MAX still produces its move_followers strobe. DONE follows on the next cycle.

Optional Feature:
SCROLL_BCD_EN:
- Defined: adds output score_bcd [7:0], holding two packed BCD digits (tens in [7:4], ones in [3:0]).
  - Updated incrementally on the same edge as score, with the ones digit carrying at 9. No divider is used.
  - Reset value 8'h00. Saturates together with score.
  - Requires SCORE_MAX <= 99.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
Bench parameters: TICK_CYCLES=4, STEP=2, SCREEN_HEIGHT=20, SCORE_TICKS=3, LEVEL_SCORE=2, NUM_LEVELS=3, SCORE_MAX=5.
1. Reset: assert reset_n=0 asynchronously mid-run, then release -> all outputs 0 immediately; no strobe in the 8 cycles after release with move_btn=0.
2. Basic scroll: hold move_btn for 12 cycles -> 3 move_followers pulses, each 1 cycle wide, at 4-cycle spacing; y_pos steps 2,4,6; score=1.
3. Gating: drop move_btn after 2 counted cycles for 10 cycles, then re-raise -> next tick occurs 2 cycles after re-raise (counter held); no strobes while low.
4. Level and wrap: run to score=2 -> level=1, step=3. From y_pos=18, the next tick -> y_pos=1 with wrap=1 and move_followers=1 in the same cycle.
5. Saturation and DONE: run until score=5 -> done=1 on the following cycle. 40 further cycles with move_btn=1 -> y_pos, score and level unchanged, no strobes.
6. Restart and BCD: pulse restart in DONE, and separately on the same cycle as a tick -> next edge all zero, no strobe. With SCROLL_BCD_EN and SCORE_MAX=99, score 9->10 gives score_bcd 8'h09->8'h10, holding 8'h99 at saturation.
